// File: rtl/int_ctrl_multi.sv
// Parametrised priority interrupt controller: edge-latched pending bits, per-source mask,
// one-cycle start/ack pulse on acceptance, in-service hold until RTI or watchdog expiry.
module int_ctrl_multi #(
  parameter int NUM_SRC    = 2,
  parameter int VEC_STRIDE = 4,
  parameter int TIMEOUT    = 500,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               rti,
  output logic [NUM_SRC-1:0] irq_req_q,
  output logic [NUM_SRC-1:0] pending,
  output logic               start_int,
  output logic [31:0]        int_id,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic               in_service,
  output logic               timeout
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] req_dly_q, req_dly_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               start_int_q, start_int_d;
  logic [31:0]        int_id_q, int_id_d;
  logic               in_service_q, in_service_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [NUM_SRC-1:0] rise, elig;
  logic [SEL_W-1:0]   sel;

  always_comb begin
    rise = irq_req & ~req_dly_q;
    elig = pending_q & ~irq_mask;
    sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) sel = i[SEL_W-1:0];
    end

    state_d      = state_q;
    start_int_d  = 1'b0;
    ack_d        = '0;
    timeout_d    = 1'b0;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d      = SERVICE;
          start_int_d  = 1'b1;
          ack_d        = NUM_SRC'(1) << sel;
          int_id_d     = 32'(sel) * 32'(VEC_STRIDE);
          count_d      = '0;
          in_service_d = 1'b1;
        end
      end
      default: begin
        if (rti) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end else if ((TIMEOUT != 0) && (count_q == TO_LAST)) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
          timeout_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    endcase

    // A fresh rise on the bit being acked must survive, so set is applied last.
    pending_d = (pending_q & ~ack_d) | rise;
    req_dly_d = irq_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_dly_q    <= '0;
      pending_q    <= '0;
      ack_q        <= '0;
      start_int_q  <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_dly_q    <= req_dly_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      start_int_q  <= start_int_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign irq_req_q  = req_dly_q;
  assign pending    = pending_q;
  assign irq_ack    = ack_q;
  assign start_int  = start_int_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Directed bench for int_ctrl_multi: a 2-source instance driven from a vector table,
// plus a 4-source instance for collision, reset and rti/watchdog corner cases.
module tb_int_ctrl_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Two-source instance, default parameters
  logic        rst2, rti2;
  logic [1:0]  req2, mask2;
  logic [1:0]  reqq2, pend2, ack2;
  logic        start2, insvc2, to2;
  logic [31:0] id2;

  int_ctrl_multi #(.NUM_SRC(2), .VEC_STRIDE(4), .TIMEOUT(500), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst2), .irq_req(req2), .irq_mask(mask2), .rti(rti2),
    .irq_req_q(reqq2), .pending(pend2), .start_int(start2), .int_id(id2),
    .irq_ack(ack2), .in_service(insvc2), .timeout(to2)
  );

  // Four-source instance with a short watchdog
  logic        rst4, rti4;
  logic [3:0]  req4, mask4;
  logic [3:0]  reqq4, pend4, ack4;
  logic        start4, insvc4, to4;
  logic [31:0] id4;

  int_ctrl_multi #(.NUM_SRC(4), .VEC_STRIDE(8), .TIMEOUT(20), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst4), .irq_req(req4), .irq_mask(mask4), .rti(rti4),
    .irq_req_q(reqq4), .pending(pend4), .start_int(start4), .int_id(id4),
    .irq_ack(ack4), .in_service(insvc4), .timeout(to4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  mask;
    logic        rti;
    logic [1:0]  e_reqq;
    logic [1:0]  e_pend;
    logic        e_start;
    logic [31:0] e_id;
    logic [1:0]  e_ack;
    logic        e_insvc;
    logic        e_to;
  } vec_t;

  vec_t vt[10];

  int hi;
  int bad;

  initial begin
    //          rst   req    mask   rti   reqq   pend   st    id     ack    isv   to
    vt[0] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};
    vt[2] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 32'h4, 2'b10, 1'b1, 1'b0};
    vt[3] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 32'h4, 2'b00, 1'b1, 1'b0};
    vt[4] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 32'h4, 2'b00, 1'b0, 1'b0};
    vt[5] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0, 2'b01, 1'b1, 1'b0};
    vt[6] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};
    vt[7] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};
    vt[8] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};
    vt[9] = '{1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0};

    rst2 = 1'b1; req2 = '0; mask2 = '0; rti2 = 1'b0;
    rst4 = 1'b1; req4 = '0; mask4 = '0; rti4 = 1'b0;

    // ---------------- vector table on the 2-source instance ----------------
    for (int i = 0; i < 10; i++) begin
      rst2 = vt[i].rst; req2 = vt[i].req; mask2 = vt[i].mask; rti2 = vt[i].rti;
      step();
      chk($sformatf("v%0d irq_req_q", i), 32'(reqq2), 32'(vt[i].e_reqq));
      chk($sformatf("v%0d pending", i),   32'(pend2),  32'(vt[i].e_pend));
      chk($sformatf("v%0d start_int", i), 32'(start2), 32'(vt[i].e_start));
      chk($sformatf("v%0d int_id", i),    id2,         vt[i].e_id);
      chk($sformatf("v%0d irq_ack", i),   32'(ack2),   32'(vt[i].e_ack));
      chk($sformatf("v%0d in_service", i),32'(insvc2), 32'(vt[i].e_insvc));
      chk($sformatf("v%0d timeout", i),   32'(to2),    32'(vt[i].e_to));
    end

    // Mask hold-off: source 0 pending but masked for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (start2 !== 1'b0 || pend2 !== 2'b01) bad++;
    end
    chk("mask_holdoff_bad_cycles", 32'(bad), 32'd0);
    mask2 = 2'b00;
    step();
    chk("unmask start_int", 32'(start2), 32'd1);
    chk("unmask int_id", id2, 32'h0);
    chk("unmask irq_ack", 32'(ack2), 32'b01);
    rti2 = 1'b1; step(); rti2 = 1'b0; step();
    chk("unmask exit in_service", 32'(insvc2), 32'd0);

    // Watchdog: one request, no rti, in_service must last exactly 500 cycles
    req2 = 2'b10; step();
    req2 = 2'b00; step();
    chk("wd start_int", 32'(start2), 32'd1);
    chk("wd int_id", id2, 32'h4);
    hi = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (insvc2 !== 1'b1) break;
      if (to2 !== 1'b0) bad++;
      hi++;
    end
    chk("wd in_service cycles", 32'(hi), 32'd500);
    chk("wd timeout pulse", 32'(to2), 32'd1);
    step();
    chk("wd timeout one cycle", 32'(to2), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (start2 !== 1'b0 || insvc2 !== 1'b0) bad++;
    end
    chk("wd no restart", 32'(bad), 32'd0);

    // ---------------- 4-source instance ----------------
    step();
    rst4 = 1'b0;
    // Same-bit collision: src3 rises in the very cycle it is acked
    mask4 = 4'b1000; req4 = 4'b1000; step();
    req4 = 4'b0000; step();
    chk("coll masked no start", 32'(start4), 32'd0);
    chk("coll pending before", 32'(pend4), 32'b1000);
    mask4 = 4'b0000; req4 = 4'b1000; step();
    chk("coll start_int", 32'(start4), 32'd1);
    chk("coll int_id", id4, 32'h18);
    chk("coll irq_ack", 32'(ack4), 32'b1000);
    chk("coll pending kept", 32'(pend4), 32'b1000);
    req4 = 4'b0000; rti4 = 1'b1; step();
    rti4 = 1'b0; step();
    chk("coll re-accept start", 32'(start4), 32'd1);
    chk("coll re-accept int_id", id4, 32'h18);
    chk("coll pending cleared", 32'(pend4), 32'b0000);

    // Reset mid-service with pending 0110; irq_req[1] stays high through reset
    req4 = 4'b0110; step();
    chk("rst pre pending", 32'(pend4), 32'b0110);
    chk("rst pre in_service", 32'(insvc4), 32'd1);
    req4 = 4'b0010; rst4 = 1'b1; step();
    chk("rst irq_req_q", 32'(reqq4), 32'd0);
    chk("rst pending", 32'(pend4), 32'd0);
    chk("rst int_id", id4, 32'h0);
    chk("rst outputs", {28'd0, start4, insvc4, to4, |ack4}, 32'd0);
    rst4 = 1'b0; step();
    chk("post-rst pending", 32'(pend4), 32'b0010);
    chk("post-rst no early start", 32'(start4), 32'd0);
    chk("post-rst no timeout", 32'(to4), 32'd0);
    step();
    chk("post-rst start_int", 32'(start4), 32'd1);
    chk("post-rst int_id", id4, 32'h8);

    // rti coincides with the final watchdog cycle: rti wins, no timeout pulse
    req4 = 4'b0000;
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (insvc4 !== 1'b1 || to4 !== 1'b0) bad++;
    end
    chk("rti-wd still in service", 32'(bad), 32'd0);
    rti4 = 1'b1; step();
    rti4 = 1'b0;
    chk("rti-wd in_service", 32'(insvc4), 32'd0);
    chk("rti-wd timeout", 32'(to4), 32'd0);
    step();
    chk("rti-wd timeout later", 32'(to4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl_multi.md
Name: int_ctrl_multi

Overview:
- Parametrised interrupt controller that replaces the fixed two-source (button/syscall) unit.
- Edge-latches NUM_SRC request lines into per-source pending bits and applies a per-source mask.
- Selects the highest-priority unmasked pending source, raises a one-cycle start pulse with a vector ID, then holds an in-service state until RTI or a watchdog timeout.
- Sits between the peripheral/syscall request sources and the multicycle CPU control FSM.

Parameters:
- NUM_SRC, 2, number of interrupt sources (1..32); higher index means higher priority.
- VEC_STRIDE, 4, byte distance between consecutive vector IDs; int_id = index*VEC_STRIDE.
- TIMEOUT, 500, in-service cycles before forced exit; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- irq_req  in  NUM_SRC  raw request lines, level, synchronous to clk.
- irq_mask  in  NUM_SRC  1 = source blocked from selection (edges still latched).
- rti  in  1  return-from-interrupt strobe from the CPU.
- irq_req_q  out  NUM_SRC  irq_req registered one cycle (status/debug mirror).
- pending  out  NUM_SRC  latched pending bits.
- start_int  out  1  one-cycle pulse on acceptance.
- int_id  out  32  vector ID of the accepted source; held until the next acceptance.
- irq_ack  out  NUM_SRC  one-hot pulse, same cycle as start_int.
- in_service  out  1  high while servicing.
- timeout  out  1  one-cycle pulse on watchdog exit.

Behaviour:
- Reset (rst=1 at a clock edge) clears all outputs and internal state: irq_req_q, pending, irq_ack, int_id, count all 0; start_int, in_service, timeout 0; state IDLE. Reset mid-service aborts service with no timeout pulse.
- Edge detect: rise[i] = irq_req[i] & ~irq_req_q[i]. A line held high through reset produces a rise on the first cycle after reset.
- Pending update: pending <= (pending & ~irq_ack_next) | rise. Set wins when a rise and an ack hit the same bit in one cycle. A second rise while pending is set is absorbed (no counting).
- Eligibility: elig = pending & ~irq_mask. sel = highest set index of elig.
- FSM states: IDLE and SERVICE.
- IDLE, when elig != 0 at a clock edge:
  - next state SERVICE; start_int=1; irq_ack[sel]=1; int_id=sel*VEC_STRIDE (zero-extended to 32 bits); count=0; in_service=1.
  - Latency: request rise at edge N gives pending at N+1 and start_int at N+2.
- IDLE with elig == 0: hold all outputs. start_int, irq_ack and timeout are 0 in every cycle not explicitly pulsed.
- SERVICE, evaluated in priority order:
  - rti=1: go to IDLE, in_service=0, timeout=0.
  - else TIMEOUT!=0 and count==TIMEOUT-1: go to IDLE, in_service=0, timeout=1.
  - else count<=count+1 and stay in SERVICE.
  - With TIMEOUT=500 and no RTI, in_service stays high for exactly 500 cycles.
- No nesting: new pending bits accumulate during SERVICE and are not accepted until IDLE.
- Earliest re-acceptance is one cycle after exit; there is always at least one IDLE cycle between services.
- rti in IDLE is ignored.
- Mask changes act combinationally on selection in the same cycle. Masking the in-service source does not end service.
- int_id holds its last value through IDLE.

Test Plan:
- Priority: NUM_SRC=2; pulse irq_req=2'b11 for one cycle -> two cycles later start_int=1, irq_ack=2'b10, int_id=0x4; pending=2'b01 afterwards. After rti, one IDLE cycle, then start_int with int_id=0x0.
- Timeout: TIMEOUT=500; one request, no rti -> in_service high for 500 cycles, timeout pulses on the exit edge, then returns to IDLE; no second start_int.
- Mask hold-off: irq_mask=2'b01, pulse irq_req[0] -> pending=2'b01, no start_int for 100 cycles. Clear the mask -> start_int on the next edge, int_id=0x0.
- Same-bit collision: NUM_SRC=4, VEC_STRIDE=8; src3 rises in the cycle it is being acked -> pending[3] stays 1. After rti, int_id=0x18 is accepted again.
- Reset mid-service: assert rst during SERVICE with pending=4'b0110 -> the next cycle shows all outputs 0, state IDLE, no timeout pulse. With irq_req[1] held high across reset -> start_int, int_id=0x8, two cycles after rst drops.
- Simultaneous rti and watchdog at count==TIMEOUT-1 -> exit via rti, timeout stays 0.
